// File: rtl/simd_dotp_mac_unit.sv
// ============================================================================
// simd_dotp_mac_unit : packed-SIMD dot-product/accumulate with circular weights
// Rev 1.0
// ============================================================================
`default_nettype none

module simd_dotp_mac_unit #(
  parameter int XLEN          = 32,
  parameter int ELEN          = 8,
  parameter int DEPTH         = 16,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [1:0]                 op_i,
  input  logic                       sign_a_i,
  input  logic                       sign_w_i,
  input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
  input  logic [XLEN-1:0]            operand_a_i,
  input  logic [XLEN-1:0]            operand_b_i,
  input  logic [XLEN-1:0]            operand_c_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            result_o,
  output logic [TRANS_ID_BITS-1:0]   trans_id_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int LANES = XLEN / ELEN;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int PRODW = 2 * ELEN + 2;
  localparam int SUMW  = XLEN + $clog2(LANES) + 1;

  localparam logic [1:0] OP_DOTP   = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_REWIND = 2'b11;

  logic                       stall;
  logic                       accept;
  logic [XLEN-1:0]            wbuf [DEPTH];
  logic [CW-1:0]              count;
  logic [PW-1:0]              rd_ptr;
  logic [XLEN-1:0]            weight;
  logic                       buf_empty;
  logic                       buf_full;
  logic                       rd_wrap;
  logic signed [PRODW-1:0]    prod [LANES];

  logic [XLEN-1:0]            op_val;
  logic                       op_err;
  logic                       op_use_sum;

  logic                       s1_valid;
  logic signed [PRODW-1:0]    s1_prod [LANES];
  logic [XLEN-1:0]            s1_val;
  logic                       s1_use_sum;
  logic                       s1_err;
  logic [TRANS_ID_BITS-1:0]   s1_id;

  logic signed [SUMW-1:0]     acc;
  logic                       unused_sum_msbs;

  assign stall     = valid_o & ~ready_i;
  assign ready_o   = ~stall;
  assign accept    = valid_i & ready_o;
  assign count_o   = count;
  assign buf_empty = (count == '0);
  assign buf_full  = (count == CW'(DEPTH));
  assign weight    = wbuf[rd_ptr];
  assign rd_wrap   = (({1'b0, rd_ptr} + CW'(1)) == count);

  // Each lane is widened to ELEN+1 bits so signed and unsigned share one multiplier.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ELEN:0]    xa;
    logic signed [ELEN:0]    xw;
    logic signed [PRODW-1:0] pa;
    logic signed [PRODW-1:0] pw;
    assign xa = {sign_a_i & operand_a_i[g*ELEN+ELEN-1], operand_a_i[g*ELEN +: ELEN]};
    assign xw = {sign_w_i & weight[g*ELEN+ELEN-1], weight[g*ELEN +: ELEN]};
    assign pa = PRODW'(xa);
    assign pw = PRODW'(xw);
    assign prod[g] = pa * pw;
  end

  always_comb begin
    op_val     = '0;
    op_err     = 1'b0;
    op_use_sum = 1'b0;
    case (op_i)
      OP_DOTP: begin
        op_val     = operand_c_i;
        op_err     = buf_empty;
        op_use_sum = ~buf_empty;
      end
      OP_LOAD: begin
        op_val = buf_full ? XLEN'(DEPTH) : XLEN'(count) + XLEN'(1);
        op_err = buf_full;
      end
      OP_CLEAR:  op_val = '0;
      OP_REWIND: op_val = XLEN'(count);
      default:   op_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept && op_i == OP_LOAD && !buf_full)
      wbuf[count[PW-1:0]] <= operand_b_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (accept) begin
      case (op_i)
        OP_DOTP:   if (!buf_empty) rd_ptr <= rd_wrap ? '0 : rd_ptr + PW'(1);
        OP_LOAD:   if (!buf_full) count <= count + CW'(1);
        OP_CLEAR: begin
          count  <= '0;
          rd_ptr <= '0;
        end
        OP_REWIND: rd_ptr <= '0;
        default: ;
      endcase
    end
  end

  // Non-DOTP results ride in s1_val with the lane sum masked off.
  always_comb begin
    acc = {{(SUMW-XLEN){1'b0}}, s1_val};
    for (int i = 0; i < LANES; i++)
      if (s1_use_sum) acc = acc + SUMW'(s1_prod[i]);
  end

  assign unused_sum_msbs = ^acc[SUMW-1:XLEN];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1_val     <= '0;
      s1_use_sum <= 1'b0;
      s1_err     <= 1'b0;
      s1_id      <= '0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
      valid_o    <= 1'b0;
      result_o   <= '0;
      trans_id_o <= '0;
      err_o      <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_val     <= op_val;
        s1_use_sum <= op_use_sum;
        s1_err     <= op_err;
        s1_id      <= trans_id_i;
        for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
      end
      valid_o <= s1_valid;
      if (s1_valid) begin
        result_o   <= acc[XLEN-1:0];
        trans_id_o <= s1_id;
        err_o      <= s1_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_dotp_mac_unit.sv
// ============================================================================
// tb_simd_dotp_mac_unit : directed bench, ELEN=8/DEPTH=16 and ELEN=16/DEPTH=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_simd_dotp_mac_unit;

  localparam logic [1:0] DOTP = 2'b00, LOAD = 2'b01, CLEAR = 2'b10, REWIND = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        sa = 1'b0, sw = 1'b0;
  logic [2:0]  id_in = 3'd0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        rdy_in = 1'b1;

  logic        rdy8, v8, e8;
  logic [31:0] r8;
  logic [2:0]  id8;
  logic [4:0]  cnt8;
  logic        rdy16, v16, e16;
  logic [31:0] r16;
  logic [2:0]  id16;
  logic [2:0]  cnt16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] next_id = 3'd0;

  always #5 clk = ~clk;

  simd_dotp_mac_unit dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(rdy8), .op_i(op),
    .sign_a_i(sa), .sign_w_i(sw), .trans_id_i(id_in), .operand_a_i(a),
    .operand_b_i(b), .operand_c_i(c), .valid_o(v8), .ready_i(rdy_in),
    .result_o(r8), .trans_id_o(id8), .err_o(e8), .count_o(cnt8)
  );

  simd_dotp_mac_unit #(.XLEN(32), .ELEN(16), .DEPTH(4), .TRANS_ID_BITS(3)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(rdy16), .op_i(op),
    .sign_a_i(sa), .sign_w_i(sw), .trans_id_i(id_in), .operand_a_i(a),
    .operand_b_i(b), .operand_c_i(c), .valid_o(v16), .ready_i(rdy_in),
    .result_o(r16), .trans_id_o(id16), .err_o(e16), .count_o(cnt16)
  );

  typedef struct {
    logic [1:0]  op;
    logic        sa;
    logic        sw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic        err;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_op(input logic [1:0] o, input logic s_a, input logic s_w,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
    int w;
    valid_in = 1'b1; op = o; sa = s_a; sw = s_w; a = va; b = vb; c = vc; id_in = next_id;
    w = 0;
    @(negedge clk);
    while (!rdy8 && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (w >= 20) check("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    next_id  = next_id + 3'd1;
  endtask

  task automatic run_op(input bit use16, input string name, input logic [1:0] o,
                        input logic s_a, input logic s_w, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] vc,
                        input logic [31:0] exp_res, input logic exp_err,
                        input logic [4:0] exp_cnt, input bit chk_lat);
    logic [2:0] exp_id;
    int lat;
    @(posedge clk);
    #1;
    exp_id = next_id;
    send_op(o, s_a, s_w, va, vb, vc);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(use16 ? v16 : v8) && lat < 10);
    if (!(use16 ? v16 : v8)) check({name, "_timeout"}, 64'd1, 64'd0);
    check({name, "_result"}, use16 ? r16 : r8, exp_res);
    check({name, "_err"},    use16 ? e16 : e8, exp_err);
    check({name, "_id"},     use16 ? id16 : id8, exp_id);
    check({name, "_count"},  use16 ? {2'b00, cnt16} : cnt8, exp_cnt);
    if (chk_lat) check({name, "_latency"}, lat, 64'd2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    next_id = 3'd0;
  endtask

  int got, cyc, seen, w;
  logic [31:0] bp_exp [4];
  logic [2:0]  bp_id0;

  initial begin
    vecs[0]  = '{LOAD,   1'b0, 1'b0, 32'h0,        32'h01020304, 32'h0,        32'd1,        1'b0, 5'd1};
    vecs[1]  = '{DOTP,   1'b0, 1'b0, 32'h01010101, 32'h0,        32'd5,        32'd15,       1'b0, 5'd1};
    vecs[2]  = '{CLEAR,  1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'd0,        1'b0, 5'd0};
    vecs[3]  = '{LOAD,   1'b0, 1'b0, 32'h0,        32'hFF807F01, 32'h0,        32'd1,        1'b0, 5'd1};
    vecs[4]  = '{DOTP,   1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h0,        32'd1,        1'b0, 5'd1};
    vecs[5]  = '{DOTP,   1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0001FD01, 1'b0, 5'd1};
    vecs[6]  = '{DOTP,   1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h10,       32'hFFFFFE11, 1'b0, 5'd1};
    vecs[7]  = '{CLEAR,  1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'd0,        1'b0, 5'd0};
    vecs[8]  = '{LOAD,   1'b0, 1'b0, 32'h0,        32'h01010101, 32'h0,        32'd1,        1'b0, 5'd1};
    vecs[9]  = '{LOAD,   1'b0, 1'b0, 32'h0,        32'h02020202, 32'h0,        32'd2,        1'b0, 5'd2};
    vecs[10] = '{DOTP,   1'b0, 1'b0, 32'h01010101, 32'h0,        32'h0,        32'd4,        1'b0, 5'd2};
    vecs[11] = '{DOTP,   1'b0, 1'b0, 32'h01010101, 32'h0,        32'h0,        32'd8,        1'b0, 5'd2};
    vecs[12] = '{DOTP,   1'b0, 1'b0, 32'h01010101, 32'h0,        32'h0,        32'd4,        1'b0, 5'd2};
    vecs[13] = '{REWIND, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'd2,        1'b0, 5'd2};
    vecs[14] = '{DOTP,   1'b0, 1'b0, 32'h01010101, 32'h0,        32'h0,        32'd4,        1'b0, 5'd2};
    vecs[15] = '{DOTP,   1'b0, 1'b0, 32'h01010101, 32'h0,        32'h0,        32'd8,        1'b0, 5'd2};
    vecs[16] = '{CLEAR,  1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'd0,        1'b0, 5'd0};
    vecs[17] = '{DOTP,   1'b0, 1'b0, 32'h0,        32'h0,        32'h1234,     32'h1234,     1'b1, 5'd0};
    vecs[18] = '{LOAD,   1'b0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'd1,        1'b0, 5'd1};
    vecs[19] = '{DOTP,   1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0003F803, 1'b0, 5'd1};

    do_reset();
    @(negedge clk);
    check("reset_valid",  v8, 0);
    check("reset_result", r8, 0);
    check("reset_id",     id8, 0);
    check("reset_err",    e8, 0);
    check("reset_count",  cnt8, 0);
    check("reset_ready",  rdy8, 1);

    for (int i = 0; i < 20; i++)
      run_op(1'b0, $sformatf("vec%0d", i), vecs[i].op, vecs[i].sa, vecs[i].sw,
             vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res, vecs[i].err, vecs[i].cnt, i == 1);

    // Fill past capacity, then empty again.
    run_op(1'b0, "full_clear0", CLEAR, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 16; i++)
      run_op(1'b0, $sformatf("fill%0d", i), LOAD, 0, 0, 0, 32'(i), 0, 32'(i), 1'b0, 5'(i), 1'b0);
    run_op(1'b0, "overfill", LOAD, 0, 0, 0, 32'hDEAD, 0, 32'd16, 1'b1, 5'd16, 1'b0);
    run_op(1'b0, "full_clear1", CLEAR, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b0);

    // Backpressure: four back-to-back DOTPs with a 3-cycle consumer stall.
    run_op(1'b0, "bp_load0", LOAD, 0, 0, 0, 32'h01010101, 0, 32'd1, 1'b0, 5'd1, 1'b0);
    run_op(1'b0, "bp_load1", LOAD, 0, 0, 0, 32'h02020202, 0, 32'd2, 1'b0, 5'd2, 1'b0);
    bp_exp[0] = 32'd4; bp_exp[1] = 32'd108; bp_exp[2] = 32'd204; bp_exp[3] = 32'd308;
    @(posedge clk);
    #1;
    bp_id0 = next_id;
    got = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_op(DOTP, 0, 0, 32'h01010101, 0, 32'(i * 100));
      end
      begin
        w = 0;
        while (!v8 && w < 30) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy_in = 1'b1;
      end
      begin
        cyc = 0;
        while (got < 4 && cyc < 60) begin
          @(negedge clk);
          cyc++;
          if (v8 && !rdy_in) check("bp_ready_low", rdy8, 0);
          if (v8 && rdy_in) begin
            check($sformatf("bp_result%0d", got), r8, bp_exp[got]);
            check($sformatf("bp_id%0d", got), id8, 3'(bp_id0 + 3'(got)));
            got++;
          end
        end
      end
    join
    check("bp_result_count", got, 4);

    // Reset with two ops in flight.
    @(posedge clk);
    #1;
    send_op(LOAD, 0, 0, 0, 32'h05050505, 0);
    send_op(DOTP, 0, 0, 32'h01010101, 0, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", v8, 0);
    check("midrst_count", cnt8, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_id = 3'd0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (v8) seen++;
    end
    check("midrst_no_stale", seen, 0);
    check("midrst_ready", rdy8, 1);

    // Wide elements, shallow buffer.
    do_reset();
    run_op(1'b1, "e16_load", LOAD, 0, 0, 0, 32'h01020304, 0, 32'd1, 1'b0, 5'd1, 1'b0);
    run_op(1'b1, "e16_dotp", DOTP, 0, 0, 32'h00010001, 0, 32'd5, 32'd1035, 1'b0, 5'd1, 1'b1);
    run_op(1'b1, "e16_clear", CLEAR, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b0);
    run_op(1'b1, "e16_load_s", LOAD, 0, 0, 0, 32'h8000FFFF, 0, 32'd1, 1'b0, 5'd1, 1'b0);
    run_op(1'b1, "e16_signed", DOTP, 1, 1, 32'hFFFFFFFF, 0, 0, 32'h00008001, 1'b0, 5'd1, 1'b0);
    run_op(1'b1, "e16_unsigned", DOTP, 0, 0, 32'hFFFFFFFF, 0, 0, 32'h7FFD8001, 1'b0, 5'd1, 1'b0);
    run_op(1'b1, "e16_clear2", CLEAR, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 4; i++)
      run_op(1'b1, $sformatf("e16_fill%0d", i), LOAD, 0, 0, 0, 32'(i), 0, 32'(i), 1'b0, 5'(i), 1'b0);
    run_op(1'b1, "e16_overfill", LOAD, 0, 0, 0, 32'h9, 0, 32'd4, 1'b1, 5'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
